// File: rtl/framebuffer_read_if.sv
// Avalon-MM burst-read bus plus pixel valid/ready stream for the scanout reader.
interface framebuffer_read_if;
    logic [28:0] address;
    logic [7:0]  burstcount;
    logic        read;
    logic        waitrequest;
    logic [63:0] readdata;
    logic        readdatavalid;
    logic [31:0] pixel_data;
    logic        pixel_valid;
    logic        pixel_ready;
    logic        pixel_last;

    modport master (
        output address, burstcount, read,
        input  waitrequest, readdata, readdatavalid,
        output pixel_data, pixel_valid, pixel_last,
        input  pixel_ready
    );

    modport slave (
        input  address, burstcount, read,
        output waitrequest, readdata, readdatavalid,
        input  pixel_data, pixel_valid, pixel_last,
        output pixel_ready
    );
endinterface

// File: rtl/framebuffer_read.sv
// Scanout reader: bursts one frame out of DDR3 and unpacks it into a 32-bit pixel stream.
module framebuffer_read #(
    parameter logic [28:0] FRAMEBUFFER1_START = 29'h0700_0000,
    parameter logic [28:0] FRAMEBUFFER2_START = 29'h0702_5800,
    parameter int          FRAME_WORDS        = 153600,
    parameter int          BURST_LEN          = 16,
    parameter int          FIFO_DEPTH         = 64
) (
    input  logic                clock,
    input  logic                reset,
    framebuffer_read_if.master  bus,
    input  logic                buffer,
    input  logic                frame_start,
    output logic                frame_busy,
    output logic [3:0]          state
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = AW + 1;
    localparam int NPIX = 2 * FRAME_WORDS;
    localparam int PW   = $clog2(NPIX);

    localparam logic [28:0]   BL_A     = 29'(BURST_LEN);
    localparam logic [28:0]   FW_A     = 29'(FRAME_WORDS);
    localparam logic [CW-1:0] BL_C     = CW'(BURST_LEN);
    localparam logic [PW-1:0] LAST_PIX = PW'(NPIX - 1);

    typedef enum logic [3:0] {
        IDLE        = 4'd0,
        REQUEST     = 4'd1,
        WAIT_CREDIT = 4'd2,
        DRAIN       = 4'd3
    } state_e;

    state_e        state_q;
    logic [28:0]   base_q;
    logic [28:0]   word_addr_q;
    logic [28:0]   address_q;
    logic          read_q;
    logic          busy_q;
    logic          half_q;
    logic          done_q;
    logic [CW-1:0] out_q;
    logic [CW-1:0] cnt_q;
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [PW-1:0] pix_q;
    logic [63:0]   mem_q [FIFO_DEPTH];

    logic [CW-1:0] out_d;
    logic [CW-1:0] cnt_d;
    logic [28:0]   next_word;
    logic [28:0]   start_base;
    logic [63:0]   head;
    logic          valid;
    logic          accept;
    logic          beat;
    logic          hs;
    logic          pop;
    logic          last_hs;
    logic          credit_n;

    always_comb begin
        valid      = (cnt_q != '0);
        accept     = (state_q == REQUEST) && read_q && !bus.waitrequest;
        beat       = bus.readdatavalid;
        hs         = valid && bus.pixel_ready;
        pop        = hs && half_q;
        last_hs    = hs && (pix_q == LAST_PIX);
        out_d      = out_q + (accept ? BL_C : '0) - (beat ? CW'(1) : '0);
        cnt_d      = cnt_q + (beat ? CW'(1) : '0) - (pop ? CW'(1) : '0);
        // Credit is judged on next-cycle counts so a held request stays legal.
        credit_n   = (32'(cnt_d) + 32'(out_d) + 32'(BURST_LEN))
                     <= 32'(FIFO_DEPTH);
        next_word  = word_addr_q + BL_A;
        start_base = buffer ? FRAMEBUFFER2_START : FRAMEBUFFER1_START;
        head       = mem_q[rd_ptr_q];
    end

    assign bus.address     = address_q;
    assign bus.burstcount  = 8'(BURST_LEN);
    assign bus.read        = read_q;
    assign bus.pixel_valid = valid;
    assign bus.pixel_data  = half_q ? head[63:32] : head[31:0];
    assign bus.pixel_last  = valid && (pix_q == LAST_PIX);
    assign frame_busy      = busy_q;
    assign state           = state_q;

    always_ff @(posedge clock) begin
        if (beat) begin
            mem_q[wr_ptr_q] <= bus.readdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            base_q      <= '0;
            word_addr_q <= '0;
            address_q   <= '0;
            read_q      <= 1'b0;
            busy_q      <= 1'b0;
            half_q      <= 1'b0;
            done_q      <= 1'b0;
            out_q       <= '0;
            cnt_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            pix_q       <= '0;
        end else begin
            out_q <= out_d;
            cnt_q <= cnt_d;
            if (beat) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (hs) begin
                half_q <= !half_q;
                pix_q  <= last_hs ? '0 : pix_q + PW'(1);
            end
            if (last_hs) begin
                done_q <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (frame_start) begin
                        base_q      <= start_base;
                        word_addr_q <= '0;
                        address_q   <= start_base;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        read_q      <= credit_n;
                        state_q     <= REQUEST;
                    end
                end
                REQUEST: begin
                    if (accept) begin
                        word_addr_q <= next_word;
                        if (next_word == FW_A) begin
                            read_q  <= 1'b0;
                            state_q <= DRAIN;
                        end else if (credit_n) begin
                            address_q <= base_q + next_word;
                        end else begin
                            read_q  <= 1'b0;
                            state_q <= WAIT_CREDIT;
                        end
                    end else if (!read_q) begin
                        if (credit_n) begin
                            read_q    <= 1'b1;
                            address_q <= base_q + word_addr_q;
                        end else begin
                            state_q <= WAIT_CREDIT;
                        end
                    end
                end
                WAIT_CREDIT: begin
                    if (credit_n) begin
                        read_q    <= 1'b1;
                        address_q <= base_q + word_addr_q;
                        state_q   <= REQUEST;
                    end
                end
                DRAIN: begin
                    if (out_q == '0 && (done_q || last_hs)) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    read_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_framebuffer_read.sv
// Randomized bench for framebuffer_read: DDR3 slave model, pixel sink and frame reference.
module tb_framebuffer_read;
    localparam int FW    = 256;
    localparam int BL    = 16;
    localparam int DEPTH = 64;
    localparam int NPIX  = 2 * FW;
    localparam logic [28:0] B0 = 29'h0700_0000;
    localparam logic [28:0] B1 = 29'h0702_5800;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       buffer = 1'b0;
    logic       frame_start = 1'b0;
    logic       frame_busy;
    logic [3:0] state;

    framebuffer_read_if bus ();

    framebuffer_read #(
        .FRAMEBUFFER1_START(B0),
        .FRAMEBUFFER2_START(B1),
        .FRAME_WORDS(FW),
        .BURST_LEN(BL),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus),
        .buffer(buffer),
        .frame_start(frame_start),
        .frame_busy(frame_busy),
        .state(state)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    logic [31:0] salt;

    logic [28:0] beats[$];
    logic [28:0] cmds[$];
    int stall_left = 0;
    int stall_seen = 0;
    int hold_err = 0;
    int credit_err = 0;
    int bc_err = 0;
    int acc_words = 0;
    int pix_idx = 0;
    int pix_err = 0;
    int stab_err = 0;
    int last_seen = 0;
    int bad_idx = 0;
    logic [31:0] bad_got, bad_want;
    bit rand_wait = 0;
    bit rand_gap = 0;
    bit rand_ready = 0;
    bit hold_ready = 0;
    logic [28:0] exp_base = B0;

    logic        prev_stall = 0;
    logic        prev_vs = 0;
    logic [28:0] prev_addr;
    logic [7:0]  prev_bc;
    logic [31:0] prev_pd;
    logic        prev_pl;

    // Memory contents: each DDR word holds two distinct pixel values.
    function automatic logic [63:0] word_data(input logic [28:0] a);
        logic [31:0] lo;
        lo = ({3'b0, a} * 32'h9E37_79B1) ^ salt;
        return {~lo ^ {3'b0, a}, lo};
    endfunction

    function automatic logic [31:0] exp_pixel(input logic [28:0] base, input int p);
        logic [63:0] w;
        w = word_data(base + 29'(p / 2));
        return (p % 2 == 1) ? w[63:32] : w[31:0];
    endfunction

    initial begin
        logic [31:0] want;
        bus.waitrequest   = 1'b0;
        bus.readdatavalid = 1'b0;
        bus.readdata      = '0;
        bus.pixel_ready   = 1'b0;
        forever begin
            @(negedge clock);
            if (reset) begin
                beats.delete();
                bus.waitrequest   = 1'b0;
                bus.readdatavalid = 1'b0;
                bus.pixel_ready   = 1'b0;
                prev_stall = 0;
                prev_vs    = 0;
            end else begin
                if (prev_stall && (bus.read !== 1'b1 || bus.address !== prev_addr
                                   || bus.burstcount !== prev_bc))
                    hold_err++;
                if (bus.read && stall_left > 0) begin
                    bus.waitrequest = 1'b1;
                    stall_left--;
                    stall_seen++;
                end else begin
                    bus.waitrequest = bus.read && rand_wait && ($urandom_range(3) == 0);
                end
                if (beats.size() > 0 && (!rand_gap || $urandom_range(2) != 0)) begin
                    bus.readdatavalid = 1'b1;
                    bus.readdata      = word_data(beats.pop_front());
                end else begin
                    bus.readdatavalid = 1'b0;
                    bus.readdata      = {$urandom, $urandom};
                end
                if (bus.read && !bus.waitrequest) begin
                    if (acc_words - pix_idx / 2 + BL > DEPTH) credit_err++;
                    if (bus.burstcount !== 8'(BL)) bc_err++;
                    cmds.push_back(bus.address);
                    acc_words += BL;
                    for (int i = 0; i < BL; i++) beats.push_back(bus.address + 29'(i));
                end
                prev_stall = bus.read && bus.waitrequest;
                prev_addr  = bus.address;
                prev_bc    = bus.burstcount;

                if (prev_vs && (bus.pixel_valid !== 1'b1 || bus.pixel_data !== prev_pd
                                || bus.pixel_last !== prev_pl))
                    stab_err++;
                bus.pixel_ready = !hold_ready && (!rand_ready || $urandom_range(3) != 0);
                if (bus.pixel_valid && bus.pixel_ready) begin
                    want = exp_pixel(exp_base, pix_idx);
                    if (bus.pixel_data !== want || bus.pixel_last !== (pix_idx == NPIX - 1)) begin
                        if (pix_err == 0) begin
                            bad_idx  = pix_idx;
                            bad_got  = bus.pixel_data;
                            bad_want = want;
                        end
                        pix_err++;
                    end
                    if (bus.pixel_last) last_seen++;
                    pix_idx++;
                end
                prev_vs = bus.pixel_valid && !bus.pixel_ready;
                prev_pd = bus.pixel_data;
                prev_pl = bus.pixel_last;
            end
        end
    end

    task automatic start_frame(input logic b, input logic [28:0] eb);
        buffer      = b;
        frame_start = 1'b1;
        exp_base    = eb;
        acc_words   = 0;
        pix_idx     = 0;
        pix_err     = 0;
        stab_err    = 0;
        hold_err    = 0;
        credit_err  = 0;
        bc_err      = 0;
        last_seen   = 0;
        stall_seen  = 0;
        cmds.delete();
        @(negedge clock);
        frame_start = 1'b0;
    endtask

    task automatic wait_done(output bit timeout);
        timeout = 1;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clock);
            if (!frame_busy) begin
                timeout = 0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checks++; if (bus.read !== 1'b0) begin errors++; $display("FAIL reset_read got %b want 0", bus.read); end
        checks++; if (bus.address !== 29'h0) begin errors++; $display("FAIL reset_address got %h want 0", bus.address); end
        checks++; if (bus.burstcount !== 8'(BL)) begin errors++; $display("FAIL reset_burstcount got %0d want %0d", bus.burstcount, BL); end
        checks++; if (bus.pixel_valid !== 1'b0) begin errors++; $display("FAIL reset_pixel_valid got %b want 0", bus.pixel_valid); end
        checks++; if (bus.pixel_last !== 1'b0) begin errors++; $display("FAIL reset_pixel_last got %b want 0", bus.pixel_last); end
        checks++; if (frame_busy !== 1'b0) begin errors++; $display("FAIL reset_frame_busy got %b want 0", frame_busy); end
        checks++; if (state !== 4'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_buffer0;
        bit to;
        int seq_bad;
        rand_wait = 0; rand_gap = 0; rand_ready = 0;
        start_frame(1'b0, B0);
        wait_done(to);
        seq_bad = 0;
        foreach (cmds[i]) if (cmds[i] !== B0 + 29'(i * BL)) seq_bad++;
        checks++; if (to) begin errors++; $display("FAIL b0_timeout got busy=1 want busy=0"); end
        checks++; if (cmds.size() != FW / BL) begin errors++; $display("FAIL b0_bursts got %0d want %0d", cmds.size(), FW / BL); end
        checks++; if (cmds[0] !== B0) begin errors++; $display("FAIL b0_first_addr got %h want %h", cmds[0], B0); end
        checks++; if (cmds[$] !== B0 + 29'(FW - BL)) begin errors++; $display("FAIL b0_last_addr got %h want %h", cmds[$], B0 + 29'(FW - BL)); end
        checks++; if (seq_bad != 0) begin errors++; $display("FAIL b0_addr_seq got %0d bad want 0", seq_bad); end
        checks++; if (pix_idx != NPIX) begin errors++; $display("FAIL b0_pixel_count got %0d want %0d", pix_idx, NPIX); end
        checks++; if (pix_err != 0) begin errors++; $display("FAIL b0_pixels got %0d bad (idx %0d got %h want %h) want 0", pix_err, bad_idx, bad_got, bad_want); end
        checks++; if (last_seen != 1) begin errors++; $display("FAIL b0_last_count got %0d want 1", last_seen); end
        checks++; if (credit_err + bc_err != 0) begin errors++; $display("FAIL b0_credit_bc got %0d want 0", credit_err + bc_err); end
    endtask

    task automatic test_buffer1_toggle;
        bit to;
        int seq_bad;
        rand_wait = 1; rand_gap = 1; rand_ready = 1;
        start_frame(1'b1, B1);
        to = 1;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clock);
            buffer = 1'($urandom);
            if (!frame_busy) begin
                to = 0;
                break;
            end
        end
        seq_bad = 0;
        foreach (cmds[i]) if (cmds[i] !== B1 + 29'(i * BL)) seq_bad++;
        checks++; if (to) begin errors++; $display("FAIL b1_timeout got busy=1 want busy=0"); end
        checks++; if (cmds[0] !== B1) begin errors++; $display("FAIL b1_first_addr got %h want %h", cmds[0], B1); end
        checks++; if (cmds[$] !== B1 + 29'(FW - BL)) begin errors++; $display("FAIL b1_last_addr got %h want %h", cmds[$], B1 + 29'(FW - BL)); end
        checks++; if (seq_bad != 0 || cmds.size() != FW / BL) begin errors++; $display("FAIL b1_addr_seq got %0d bad of %0d want 0 of %0d", seq_bad, cmds.size(), FW / BL); end
        checks++; if (pix_err != 0 || pix_idx != NPIX) begin errors++; $display("FAIL b1_pixels got %0d bad %0d seen want 0 bad %0d seen", pix_err, pix_idx, NPIX); end
        checks++; if (hold_err + stab_err + credit_err != 0) begin errors++; $display("FAIL b1_protocol got hold=%0d stab=%0d credit=%0d want 0", hold_err, stab_err, credit_err); end
    endtask

    task automatic test_backpressure;
        bit to;
        int sum;
        rand_wait = 0; rand_gap = 1; rand_ready = 1;
        start_frame(1'b0, B0);
        for (int i = 0; i < 3000 && pix_idx < 100; i++) @(negedge clock);
        hold_ready = 1;
        repeat (500) @(negedge clock);
        sum = acc_words - pix_idx / 2;
        checks++; if (state !== 4'd2) begin errors++; $display("FAIL bp_state got %0d want 2", state); end
        checks++; if (bus.read !== 1'b0) begin errors++; $display("FAIL bp_read got %b want 0", bus.read); end
        checks++; if (sum <= DEPTH - BL || sum > DEPTH) begin errors++; $display("FAIL bp_credit_fill got %0d want %0d..%0d", sum, DEPTH - BL + 1, DEPTH); end
        checks++; if (bus.pixel_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_held got %b want 1", bus.pixel_valid); end
        hold_ready = 0;
        rand_ready = 0;
        wait_done(to);
        checks++; if (to) begin errors++; $display("FAIL bp_timeout got busy=1 want busy=0"); end
        checks++; if (pix_err != 0 || pix_idx != NPIX) begin errors++; $display("FAIL bp_pixels got %0d bad (idx %0d got %h want %h) %0d seen want 0 bad %0d seen", pix_err, bad_idx, bad_got, bad_want, pix_idx, NPIX); end
        checks++; if (stab_err + credit_err != 0) begin errors++; $display("FAIL bp_stable_credit got stab=%0d credit=%0d want 0", stab_err, credit_err); end
    endtask

    task automatic test_waitrequest;
        bit to;
        int seq_bad;
        rand_wait = 0; rand_gap = 0; rand_ready = 0;
        stall_left = 7;
        start_frame(1'b0, B0);
        for (int i = 0; i < 3000 && pix_idx < 64; i++) @(negedge clock);
        stall_left = 7;
        wait_done(to);
        seq_bad = 0;
        foreach (cmds[i]) if (cmds[i] !== B0 + 29'(i * BL)) seq_bad++;
        checks++; if (to) begin errors++; $display("FAIL wr_timeout got busy=1 want busy=0"); end
        checks++; if (stall_seen != 14) begin errors++; $display("FAIL wr_stalls got %0d want 14", stall_seen); end
        checks++; if (hold_err != 0 || bc_err != 0) begin errors++; $display("FAIL wr_hold got %0d changes want 0", hold_err + bc_err); end
        checks++; if (cmds.size() != FW / BL || seq_bad != 0) begin errors++; $display("FAIL wr_accept_once got %0d bursts %0d bad want %0d bursts 0 bad", cmds.size(), seq_bad, FW / BL); end
        checks++; if (pix_err != 0 || pix_idx != NPIX) begin errors++; $display("FAIL wr_pixels got %0d bad %0d seen want 0 bad %0d seen", pix_err, pix_idx, NPIX); end
    endtask

    task automatic test_busy_ignore;
        bit to;
        int seq_bad;
        rand_wait = 0; rand_gap = 1; rand_ready = 1;
        start_frame(1'b0, B0);
        to = 1;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clock);
            if (!frame_busy) begin
                frame_start = 1'b0;
                to = 0;
                break;
            end
            frame_start = (i % 50 == 10);
            buffer      = 1'b1;
        end
        seq_bad = 0;
        foreach (cmds[i]) if (cmds[i] !== B0 + 29'(i * BL)) seq_bad++;
        checks++; if (to) begin errors++; $display("FAIL busy_timeout got busy=1 want busy=0"); end
        checks++; if (cmds.size() != FW / BL || seq_bad != 0) begin errors++; $display("FAIL busy_ignored got %0d bursts %0d bad want %0d bursts 0 bad", cmds.size(), seq_bad, FW / BL); end
        checks++; if (pix_err != 0 || pix_idx != NPIX) begin errors++; $display("FAIL busy_pixels got %0d bad %0d seen want 0 bad %0d seen", pix_err, pix_idx, NPIX); end
        start_frame(1'b1, B1);
        checks++; if (frame_busy !== 1'b1) begin errors++; $display("FAIL busy_restart got %b want 1", frame_busy); end
        wait_done(to);
        checks++; if (to || cmds[0] !== B1) begin errors++; $display("FAIL busy_new_frame got timeout=%0b addr=%h want 0 %h", to, cmds[0], B1); end
        checks++; if (pix_err != 0 || pix_idx != NPIX) begin errors++; $display("FAIL busy_new_pixels got %0d bad %0d seen want 0 bad %0d seen", pix_err, pix_idx, NPIX); end
    endtask

    task automatic test_reset_mid;
        bit to;
        rand_wait = 0; rand_gap = 1; rand_ready = 1;
        start_frame(1'b0, B0);
        for (int i = 0; i < 3000 && !(pix_idx >= 20 && beats.size() > 4); i++) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        checks++; if (bus.read !== 1'b0) begin errors++; $display("FAIL rm_read got %b want 0", bus.read); end
        checks++; if (bus.pixel_valid !== 1'b0) begin errors++; $display("FAIL rm_pixel_valid got %b want 0", bus.pixel_valid); end
        checks++; if (frame_busy !== 1'b0) begin errors++; $display("FAIL rm_frame_busy got %b want 0", frame_busy); end
        checks++; if (state !== 4'd0) begin errors++; $display("FAIL rm_state got %0d want 0", state); end
        @(negedge clock);
        reset = 1'b0;
        start_frame(1'b0, B0);
        wait_done(to);
        checks++; if (to || cmds[0] !== B0 || cmds.size() != FW / BL) begin errors++; $display("FAIL rm_refetch got timeout=%0b addr=%h bursts=%0d want 0 %h %0d", to, cmds[0], cmds.size(), B0, FW / BL); end
        checks++; if (pix_err != 0 || pix_idx != NPIX) begin errors++; $display("FAIL rm_pixels got %0d bad (idx %0d got %h want %h) %0d seen want 0 bad %0d seen", pix_err, bad_idx, bad_got, bad_want, pix_idx, NPIX); end
    endtask

    initial begin
        salt = $urandom;
        test_reset();
        test_buffer0();
        test_buffer1_toggle();
        test_backpressure();
        test_waitrequest();
        test_busy_ignore();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
